// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus handshake with pipeline stall, lane select, extension and timeout.
// Define MEM_MISALIGN_EXC_EN to trap misaligned accesses; otherwise they are force-aligned.
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              exc_misalign_o,
  output logic              exc_buserr_o,
  output logic [ADDR_W-1:0] bad_addr_o
);

  // state | meaning
  // IDLE  | no access in flight; non-memory ops pass through
  // BUSY  | bus request outstanding, pipeline stalled
  // DONE  | one cycle; load result / bus error presented

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flushed_q, flushed_d;
  logic                timed_out_q, timed_out_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_sel_q, bus_sel_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  size_e               size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                buserr_q, buserr_d;
  logic [ADDR_W-1:0]   bad_addr_q, bad_addr_d;

  logic                is_load, is_store, is_mem, is_uns;
  size_e               size;
  logic                misaligned, mis_trap, start, tmo_hit;
  logic [ADDR_W-1:0]   addr_eff;
  logic [1:0]          a_eff, lane_b, lane_h, lane_sel;
  logic [3:0]          sel_new;
  logic [31:0]         wdata_new, shifted, ext;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_uns   = 1'b0;
    size     = SZ_W;
    case (aluop_i)
      EXE_LB_OP:  begin is_load = 1'b1; size = SZ_B; end
      EXE_LBU_OP: begin is_load = 1'b1; size = SZ_B; is_uns = 1'b1; end
      EXE_LH_OP:  begin is_load = 1'b1; size = SZ_H; end
      EXE_LHU_OP: begin is_load = 1'b1; size = SZ_H; is_uns = 1'b1; end
      EXE_LW_OP:  begin is_load = 1'b1; size = SZ_W; end
      EXE_SB_OP:  begin is_store = 1'b1; size = SZ_B; end
      EXE_SH_OP:  begin is_store = 1'b1; size = SZ_H; end
      EXE_SW_OP:  begin is_store = 1'b1; size = SZ_W; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = ((size == SZ_H) && mem_addr_i[0]) ||
                      ((size == SZ_W) && (mem_addr_i[1:0] != 2'b00));

`ifdef MEM_MISALIGN_EXC_EN
  assign mis_trap = is_mem & misaligned;
  assign addr_eff = mem_addr_i;
`else
  assign mis_trap = 1'b0;
  always_comb begin
    addr_eff = mem_addr_i;
    if (misaligned) begin
      addr_eff[0] = 1'b0;
      if (size == SZ_W) addr_eff[1] = 1'b0;
    end
  end
`endif

  assign start = (state_q == IDLE) && is_mem && !flush_i && !mis_trap;

  // Big-endian mirrors lane i to 3-i; a half then starts at lane 2-a.
  assign a_eff  = addr_eff[1:0];
  assign lane_b = BIG_ENDIAN ? (2'd3 - a_eff) : a_eff;
  assign lane_h = BIG_ENDIAN ? (2'd2 - a_eff) : a_eff;

  always_comb begin
    lane_sel  = 2'd0;
    sel_new   = 4'b1111;
    wdata_new = reg2_i;
    case (size)
      SZ_B: begin
        lane_sel  = lane_b;
        sel_new   = 4'b0001 << lane_b;
        wdata_new = {4{reg2_i[7:0]}};
      end
      SZ_H: begin
        lane_sel  = lane_h;
        sel_new   = 4'b0011 << lane_h;
        wdata_new = {2{reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign tmo_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flushed_d   = flushed_q;
    timed_out_d = timed_out_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    rdata_d     = rdata_q;
    buserr_d    = 1'b0;
    bad_addr_d  = bad_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = BUSY;
          cnt_d       = '0;
          flushed_d   = 1'b0;
          timed_out_d = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = addr_eff;
          bus_sel_d   = sel_new;
          bus_wdata_d = wdata_new;
          size_d      = size;
          uns_d       = is_uns;
          lane_d      = lane_sel;
        end
      end
      BUSY: begin
        if (flush_i) flushed_d = 1'b1;
        if (bus_ack_i) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          rdata_d   = bus_rdata_i;
        end else if (tmo_hit) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          timed_out_d = 1'b1;
          // A squashed instruction must not raise an exception.
          if (!(flushed_q || flush_i)) begin
            buserr_d   = 1'b1;
            bad_addr_d = bus_addr_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      flushed_q   <= 1'b0;
      timed_out_q <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= 4'b0000;
      bus_wdata_q <= 32'd0;
      size_q      <= SZ_W;
      uns_q       <= 1'b0;
      lane_q      <= 2'd0;
      rdata_q     <= 32'd0;
      buserr_q    <= 1'b0;
      bad_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flushed_q   <= flushed_d;
      timed_out_q <= timed_out_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      rdata_q     <= rdata_d;
      buserr_q    <= buserr_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

  assign shifted = rdata_q >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      SZ_B:    ext = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    ext = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = rdata_q;
    endcase
  end

  always_comb begin
    wd_o           = wd_i;
    wreg_o         = wreg_i;
    wdata_o        = wdata_i;
    stall_req_o    = 1'b0;
    exc_misalign_o = 1'b0;
    bad_addr_o     = bad_addr_q;
    case (state_q)
      IDLE: begin
        stall_req_o = start;
        if (flush_i || start) begin
          wreg_o = 1'b0;
        end else if (mis_trap) begin
          wreg_o         = 1'b0;
          exc_misalign_o = 1'b1;
          bad_addr_o     = mem_addr_i;
        end
      end
      BUSY: begin
        stall_req_o = 1'b1;
        wreg_o      = 1'b0;
      end
      DONE: begin
        if (flushed_q || flush_i || timed_out_q) wreg_o = 1'b0;
        else if (!bus_we_q) wdata_o = ext;
      end
      default: ;
    endcase
    // Combinational pass-through paths are forced quiet while reset is held.
    if (!rst) begin
      wd_o           = 5'd0;
      wreg_o         = 1'b0;
      wdata_o        = 32'd0;
      stall_req_o    = 1'b0;
      exc_misalign_o = 1'b0;
      bad_addr_o     = '0;
    end
  end

  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_we_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_sel_o    = bus_sel_q;
  assign bus_wdata_o  = bus_wdata_q;
  assign exc_buserr_o = buserr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: little- and big-endian instances driven with the same stimulus.
module tb_mem_access_unit;

  localparam logic [7:0] OP_NOP = 8'b0010_0000;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, bus_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, bus_ack_i;

  logic [4:0]  le_wd, be_wd;
  logic        le_wreg, be_wreg, le_stall, be_stall, le_req, be_req, le_we, be_we;
  logic [31:0] le_wdata, be_wdata, le_addr, be_addr, le_bwdata, be_bwdata, le_bad, be_bad;
  logic [3:0]  le_sel, be_sel;
  logic        le_mis, be_mis, le_berr, be_berr;

  int n_chk  = 0;
  int n_pass = 0;

  mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(16)) u_le (
    .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .wd_o(le_wd), .wreg_o(le_wreg), .wdata_o(le_wdata), .stall_req_o(le_stall),
    .bus_req_o(le_req), .bus_we_o(le_we), .bus_addr_o(le_addr), .bus_sel_o(le_sel),
    .bus_wdata_o(le_bwdata), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .exc_misalign_o(le_mis), .exc_buserr_o(le_berr), .bad_addr_o(le_bad)
  );

  mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(16)) u_be (
    .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .wd_o(be_wd), .wreg_o(be_wreg), .wdata_o(be_wdata), .stall_req_o(be_stall),
    .bus_req_o(be_req), .bus_we_o(be_we), .bus_addr_o(be_addr), .bus_sel_o(be_sel),
    .bus_wdata_o(be_bwdata), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .exc_misalign_o(be_mis), .exc_buserr_o(be_berr), .bad_addr_o(be_bad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_nop();
    aluop_i    = OP_NOP;
    mem_addr_i = 32'd0;
    bus_ack_i  = 1'b0;
  endtask

  // Accept at cycle 0, ack in cycle ack_cyc, result in cycle ack_cyc+1, idle after that.
  task automatic do_access(input string nm, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic [31:0] rdata, input int ack_cyc,
                           input logic is_st, input logic [31:0] exp_baddr,
                           input logic [3:0] sel_le, input logic [3:0] sel_be,
                           input logic [31:0] exp_bwdata, input logic [31:0] exp_le,
                           input logic [31:0] exp_be);
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h5555_0000;
    #1;
    check({nm, "_stall_c0"}, le_stall, 1'b1);
    check({nm, "_req_c0"}, le_req, 1'b0);
    for (int c = 1; c <= ack_cyc; c++) begin
      tick();
      if (c == ack_cyc) begin
        bus_ack_i = 1'b1;
        bus_rdata_i = rdata;
      end
      #1;
      check({nm, "_req_busy"}, le_req, 1'b1);
      check({nm, "_stall_busy"}, le_stall, 1'b1);
      if (c == 1) begin
        check({nm, "_addr"}, le_addr, exp_baddr);
        check({nm, "_we"}, le_we, is_st);
        check({nm, "_sel_le"}, le_sel, sel_le);
        check({nm, "_sel_be"}, be_sel, sel_be);
        if (is_st) check({nm, "_bwdata"}, le_bwdata, exp_bwdata);
      end
    end
    tick();
    bus_ack_i = 1'b0;
    #1;
    check({nm, "_stall_done"}, le_stall, 1'b0);
    check({nm, "_req_done"}, le_req, 1'b0);
    check({nm, "_wreg_done"}, le_wreg, 1'b1);
    check({nm, "_wdata_le"}, le_wdata, exp_le);
    check({nm, "_wdata_be"}, be_wdata, exp_be);
    tick();
    set_nop();
    #1;
    check({nm, "_stall_idle"}, le_stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    logic seen;
    rst = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    aluop_i = OP_LW; mem_addr_i = 32'h104; reg2_i = 32'h1234_5678;
    wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234_ABCD;
    #12;
    check("rst_wd", le_wd, 5'd0);
    check("rst_wreg", le_wreg, 1'b0);
    check("rst_wdata", le_wdata, 32'd0);
    check("rst_stall", le_stall, 1'b0);
    check("rst_req", le_req, 1'b0);
    set_nop();
    rst = 1'b1;
    tick();

    // Non-memory pass-through and flush in IDLE.
    wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h0000_CAFE;
    #1;
    check("pass_wdata", le_wdata, 32'h0000_CAFE);
    check("pass_wd", le_wd, 5'd3);
    check("pass_wreg", le_wreg, 1'b1);
    check("pass_stall", le_stall, 1'b0);
    flush_i = 1'b1;
    #1;
    check("flush_idle_wreg", le_wreg, 1'b0);
    flush_i = 1'b0;
    tick();

    do_access("lb103", OP_LB, 32'h103, 32'd0, 32'h80FF_1234, 1, 1'b0, 32'h103,
              4'b1000, 4'b0001, 32'd0, 32'hFFFF_FF80, 32'h0000_0034);
    do_access("lh100", OP_LH, 32'h100, 32'd0, 32'h80FF_1234, 2, 1'b0, 32'h100,
              4'b0011, 4'b1100, 32'd0, 32'h0000_1234, 32'hFFFF_80FF);
    do_access("lhu102", OP_LHU, 32'h102, 32'd0, 32'h80FF_1234, 1, 1'b0, 32'h102,
              4'b1100, 4'b0011, 32'd0, 32'h0000_80FF, 32'h0000_1234);
    do_access("sh202", OP_SH, 32'h202, 32'h0000_BEEF, 32'd0, 3, 1'b1, 32'h202,
              4'b1100, 4'b0011, 32'hBEEF_BEEF, 32'h5555_0000, 32'h5555_0000);
    do_access("sb001", OP_SB, 32'h001, 32'h1234_56A5, 32'd0, 2, 1'b1, 32'h001,
              4'b0010, 4'b0100, 32'hA5A5_A5A5, 32'h5555_0000, 32'h5555_0000);

`ifdef MEM_MISALIGN_EXC_EN
    aluop_i = OP_LW; mem_addr_i = 32'h102; wreg_i = 1'b1;
    #1;
    check("mis_exc", le_mis, 1'b1);
    check("mis_bad", le_bad, 32'h102);
    check("mis_stall", le_stall, 1'b0);
    check("mis_wreg", le_wreg, 1'b0);
    tick();
    set_nop();
    #1;
    check("mis_req", le_req, 1'b0);
    check("mis_exc_clr", le_mis, 1'b0);
`else
    do_access("lw102", OP_LW, 32'h102, 32'd0, 32'hCAFE_F00D, 1, 1'b0, 32'h100,
              4'b1111, 4'b1111, 32'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    check("lw102_mis", le_mis, 1'b0);
`endif

    // Timeout with no ack, then a late ack.
    aluop_i = OP_LW; mem_addr_i = 32'h300; wreg_i = 1'b1;
    #1;
    check("tmo_stall_c0", le_stall, 1'b1);
    n_req = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      tick();
      #1;
      if (le_req) n_req++;
      if (le_berr) seen = 1'b1;
    end
    check("tmo_req_cycles", n_req, 16);
    check("tmo_buserr", seen, 1'b1);
    check("tmo_bad_addr", le_bad, 32'h300);
    check("tmo_wreg", le_wreg, 1'b0);
    check("tmo_stall", le_stall, 1'b0);
    tick();
    set_nop();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    #1;
    check("late_ack_berr", le_berr, 1'b0);
    check("late_ack_stall", le_stall, 1'b0);
    tick();
    bus_ack_i = 1'b0;
    #1;
    check("late_ack_req", le_req, 1'b0);

    // Flush in BUSY cycle 2, ack in cycle 4.
    aluop_i = OP_LBU; mem_addr_i = 32'h101; wreg_i = 1'b1;
    #1;
    check("fl_stall_c0", le_stall, 1'b1);
    tick();
    tick();
    flush_i = 1'b1;
    #1;
    check("fl_stall_c2", le_stall, 1'b1);
    tick();
    flush_i = 1'b0;
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_FF00;
    #1;
    check("fl_req_c4", le_req, 1'b1);
    tick();
    bus_ack_i = 1'b0;
    #1;
    check("fl_wreg", le_wreg, 1'b0);
    check("fl_berr", le_berr, 1'b0);
    check("fl_stall", le_stall, 1'b0);
    tick();
    set_nop();

    // Reset mid-BUSY, then a clean LW.
    aluop_i = OP_LW; mem_addr_i = 32'h400; wreg_i = 1'b1; wd_i = 5'd9; wdata_i = 32'h7777_0000;
    tick();
    #1;
    check("mrst_req_before", le_req, 1'b1);
    rst = 1'b0;
    #1;
    check("mrst_req", le_req, 1'b0);
    check("mrst_stall", le_stall, 1'b0);
    check("mrst_wd", le_wd, 5'd0);
    check("mrst_wdata", le_wdata, 32'd0);
    check("mrst_addr", le_addr, 32'd0);
    check("mrst_sel", le_sel, 4'd0);
    tick();
    rst = 1'b1;
    do_access("lw404", OP_LW, 32'h404, 32'd0, 32'hDEAD_BEEF, 1, 1'b0, 32'h404,
              4'b1111, 4'b1111, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
